// File: rtl/jtkunio_romslot.sv
// jtkunio_romslot
// ---------------
// Responder side of the tile-layer ROM fetch handshake. A layer presents a
// 16-bit-word address on rom_addr; when that address is not already held,
// this block fetches two consecutive 16-bit SDRAM words and presents them as
// one 32-bit word together with rom_ok.
//
// Build option:
//   JTKUNIO_ROMSLOT_CACHE2_EN  - two tag/data entries with a 1-bit LRU
//                                replacement pointer. Undefined: single entry.
//
// Ports:
//   rst        in   synchronous reset, active high
//   clk        in   system clock
//   rom_cs     in   layer wants data; no new fetch starts while low
//   rom_addr   in   requested address (16-bit word units)
//   rom_data   out  {word at addr+1, word at addr}
//   rom_ok     out  rom_data is valid for the current rom_addr
//   sdram_addr out  word address to the SDRAM controller
//   sdram_req  out  request, held until sdram_ack
//   sdram_ack  in   one-cycle pulse, request accepted
//   data_rdy   in   one-cycle pulse per returned 16-bit word
//   data_read  in   SDRAM read data, valid with data_rdy
module jtkunio_romslot #(
    parameter int              AW     = 14,
    parameter int              SDW    = 22,
    parameter logic [SDW-1:0]  OFFSET = '0
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic [31:0]    rom_data,
    output logic           rom_ok,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [15:0]    data_read
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, BEAT0, BEAT1} state_t;

    state_t          state_reg;
    logic [AW-1:0]   req_addr_reg;
    logic [15:0]     low_reg;
    logic            hit;
    logic            fill;

    // The completing beat: the entry is being rewritten this cycle, so the
    // stored tag/data must not be reported as valid at the same time.
    assign fill   = (state_reg == BEAT1) && data_rdy;
    assign rom_ok = rom_cs && hit && !fill;

`ifdef JTKUNIO_ROMSLOT_CACHE2_EN
    logic [AW-1:0] tag_reg  [2];
    logic [31:0]   data_reg [2];
    logic [1:0]    valid_reg;
    logic [1:0]    match;
    logic          lru_reg;     // entry to replace on the next fill

    for (genvar gi = 0; gi < 2; gi++) begin : g_match
        assign match[gi] = valid_reg[gi] && (tag_reg[gi] == rom_addr);
    end

    assign hit      = |match;
    assign rom_data = match[1] ? data_reg[1] : data_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                tag_reg[i]  <= '0;
                data_reg[i] <= '0;
            end
            valid_reg <= '0;
            lru_reg   <= 1'b0;
        end else if (fill) begin
            tag_reg[lru_reg]   <= req_addr_reg;
            data_reg[lru_reg]  <= {data_read, low_reg};
            valid_reg[lru_reg] <= 1'b1;
            lru_reg            <= ~lru_reg;   // just-filled entry is most recent
        end else if (rom_ok) begin
            // The entry not hit becomes the replacement candidate.
            lru_reg <= match[0];
        end
    end
`else
    logic [AW-1:0] tag_reg;
    logic [31:0]   data_reg;
    logic          valid_reg;

    assign hit      = valid_reg && (tag_reg == rom_addr);
    assign rom_data = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (fill) begin
            tag_reg   <= req_addr_reg;
            data_reg  <= {data_read, low_reg};
            valid_reg <= 1'b1;
        end
    end
`endif

    // Fetch sequencer. A started fetch always runs to completion for the
    // address latched at request time; a changed rom_addr is only looked at
    // again once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sdram_req    <= 1'b0;
            sdram_addr   <= '0;
            req_addr_reg <= '0;
            low_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rom_cs && !hit) begin
                        req_addr_reg <= rom_addr;
                        sdram_addr   <= OFFSET + SDW'(rom_addr);
                        sdram_req    <= 1'b1;
                        state_reg    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        // First word may arrive in the same cycle as the ack.
                        if (data_rdy) begin
                            low_reg   <= data_read;
                            state_reg <= BEAT1;
                        end else begin
                            state_reg <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (data_rdy) begin
                        low_reg   <= data_read;
                        state_reg <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (data_rdy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkunio_romslot.sv
// Directed testbench for jtkunio_romslot (OFFSET = 22'h1000).
module tb_jtkunio_romslot;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_cs;
    logic [13:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] data_read;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    jtkunio_romslot #(.AW(14), .SDW(22), .OFFSET(22'h1000)) dut (
        .rst        (rst),
        .clk        (clk),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

`define CHK(NAME, OBS, EXP) begin \
    n_assert++; \
    assert ((OBS) === (EXP)) else begin \
        n_fail++; \
        $error("FAIL %s: observed %0h expected %0h", NAME, (OBS), (EXP)); \
    end \
end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Waits (bounded) for sdram_req; returns the cycle it was seen and whether
    // rom_ok was seen high meanwhile.
    task automatic wait_req(output int t, output bit ok_seen);
        ok_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sdram_req) break;
            cyc(); #1;
            if (rom_ok) ok_seen = 1'b1;
        end
        `CHK("req_seen", sdram_req, 1'b1)
        t = cyc_cnt;
    endtask

    // Plays the SDRAM side of one fetch. ack_wait = cycles of sdram_req
    // before the ack; combine puts the first word in the ack cycle.
    task automatic serve(input string nm, input int ack_wait,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input bit combine, input logic [21:0] exp_addr,
                         output int t_req, output bit ok_seen);
        wait_req(t_req, ok_seen);
        `CHK({nm, "_addr"}, sdram_addr, exp_addr)
        for (int i = 0; i < ack_wait; i++) begin
            `CHK({nm, "_req_held"}, sdram_req, 1'b1)
            cyc(); #1;
            if (rom_ok) ok_seen = 1'b1;
        end
        sdram_ack = 1'b1;
        if (combine) begin
            data_rdy  = 1'b1;
            data_read = w0;
        end
        cyc(); #1;
        if (rom_ok) ok_seen = 1'b1;
        sdram_ack = 1'b0;
        if (combine) begin
            data_read = w1;
            cyc(); #1;
            data_rdy = 1'b0;
        end else begin
            data_rdy  = 1'b1;
            data_read = w0;
            cyc(); #1;
            if (rom_ok) ok_seen = 1'b1;
            data_read = w1;
            cyc(); #1;
            data_rdy = 1'b0;
        end
        #1;
    endtask

    initial begin
        int t;
        bit s;
        int n_req;
        int n_bad;
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit s;
        int n_req;
        int n_bad;

        rst = 1'b1; rom_cs = 1'b0; rom_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        cyc(); cyc(); #1;
        `CHK("rst_rom_ok", rom_ok, 1'b0)
        `CHK("rst_sdram_req", sdram_req, 1'b0)
        `CHK("rst_rom_data", rom_data, 32'h0)
        `CHK("rst_sdram_addr", sdram_addr, 22'h0)

        // Cold fetch
        rst = 1'b0; rom_cs = 1'b1; rom_addr = 14'h0010;
        serve("cold", 1, 16'hBEEF, 16'hCAFE, 1'b0, 22'h1010, t, s);
        `CHK("cold_ok", rom_ok, 1'b1)
        `CHK("cold_latency", cyc_cnt - t, 4)
        `CHK("cold_early_ok", s, 1'b0)
        `CHK("cold_data", rom_data, 32'hCAFE_BEEF)

        // Re-hit for 20 cycles
        n_req = 0; n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (sdram_req) n_req++;
            if (!rom_ok) n_bad++;
        end
        `CHK("rehit_reqs", n_req, 0)
        `CHK("rehit_ok_drops", n_bad, 0)

        // Address change while waiting for the ack
        rst = 1'b1; cyc(); rst = 1'b0; #1;
        rom_addr = 14'h0010;
        wait_req(t, s);
        rom_addr = 14'h0020; #1;
        `CHK("mid_ok_after_change", rom_ok, 1'b0)
        serve("mid1", 1, 16'hDEAD, 16'h0001, 1'b0, 22'h1010, t, s);
        `CHK("mid1_ok_seen", s, 1'b0)
        `CHK("mid1_ok", rom_ok, 1'b0)
        `CHK("mid1_data", rom_data, 32'h0001_DEAD)
        rom_addr = 14'h0010; #1;
        `CHK("mid1_tag", rom_ok, 1'b1)
        rom_addr = 14'h0020; #1;
        serve("mid2", 5, 16'h1111, 16'h2222, 1'b0, 22'h1020, t, s);
        `CHK("mid2_ok_seen", s, 1'b0)
        `CHK("mid2_ok", rom_ok, 1'b1)
        `CHK("mid2_data", rom_data, 32'h2222_1111)

        // Ack coinciding with the first word
        rom_addr = 14'h0040;
        serve("comb", 1, 16'hAAAA, 16'h5555, 1'b1, 22'h1040, t, s);
        `CHK("comb_ok", rom_ok, 1'b1)
        `CHK("comb_latency", cyc_cnt - t, 3)
        `CHK("comb_data", rom_data, 32'h5555_AAAA)

        // Reset during BEAT0
        rom_addr = 14'h0050;
        wait_req(t, s);
        sdram_ack = 1'b1;
        cyc(); #1;
        sdram_ack = 1'b0;
        rst = 1'b1;
        cyc(); #1;
        `CHK("rstmid_req", sdram_req, 1'b0)
        `CHK("rstmid_ok", rom_ok, 1'b0)
        `CHK("rstmid_data", rom_data, 32'h0)
        rst = 1'b0;
        serve("refetch", 1, 16'h7777, 16'h8888, 1'b0, 22'h1050, t, s);
        `CHK("refetch_ok", rom_ok, 1'b1)
        `CHK("refetch_data", rom_data, 32'h8888_7777)

        // rom_cs low: no request
        rom_cs = 1'b0; rom_addr = 14'h0060;
        n_req = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            if (sdram_req) n_req++;
        end
        `CHK("cs_low_reqs", n_req, 0)
        `CHK("cs_low_ok", rom_ok, 1'b0)

        // Two-address working set
        rom_cs = 1'b1; rom_addr = 14'h0100;
        serve("fill100", 1, 16'h0100, 16'h0101, 1'b0, 22'h1100, t, s);
        `CHK("fill100_data", rom_data, 32'h0101_0100)
        rom_addr = 14'h0200;
        serve("fill200", 1, 16'h0200, 16'h0201, 1'b0, 22'h1200, t, s);
        `CHK("fill200_data", rom_data, 32'h0201_0200)
`ifdef JTKUNIO_ROMSLOT_CACHE2_EN
        n_req = 0; n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            rom_addr = (i % 2 == 0) ? 14'h0100 : 14'h0200;
            #1;
            if (!rom_ok) n_bad++;
            cyc(); #1;
            if (sdram_req) n_req++;
        end
        `CHK("alt_reqs", n_req, 0)
        `CHK("alt_misses", n_bad, 0)
        `CHK("alt_data", rom_data, 32'h0201_0200)
        rom_addr = 14'h0300;
        serve("fill300", 1, 16'h0300, 16'h0301, 1'b0, 22'h1300, t, s);
        `CHK("fill300_data", rom_data, 32'h0301_0300)
        rom_addr = 14'h0200; #1;
        `CHK("kept200_ok", rom_ok, 1'b1)
        `CHK("kept200_data", rom_data, 32'h0201_0200)
        rom_addr = 14'h0100; #1;
        `CHK("evicted100_ok", rom_ok, 1'b0)
        serve("refill100", 1, 16'h0100, 16'h0101, 1'b0, 22'h1100, t, s);
        `CHK("refill100_ok", rom_ok, 1'b1)
`else
        rom_addr = 14'h0100; #1;
        `CHK("single_evict_ok", rom_ok, 1'b0)
        serve("refill100", 1, 16'h0100, 16'h0101, 1'b0, 22'h1100, t, s);
        `CHK("refill100_ok", rom_ok, 1'b1)
        `CHK("refill100_data", rom_data, 32'h0101_0100)
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
